// File: rtl/gray_run_ctrl_pkg.sv
// Shared definitions for the gray counter run sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state codes and default widths for Steps and for the counter code.
package gray_run_ctrl_pkg;

  localparam int STEPW_DEF = 8;  // width of Steps / remaining-step counter
  localparam int CW_DEF    = 3;  // gray counter code width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

endpackage

// File: rtl/gray_counter.sv
// 3-bit (CW-bit) gray code counter with a sticky wrap flag.
// Latency: Output advances one code on each Clk edge with En=1.
// Backpressure: En=0 holds the code; Reset (sync, high) clears code and Overflow.
// Ports: Clk, Reset, En in; Output (gray code), Overflow (set on last-code -> 0 wrap) out.
module gray_counter
  import gray_run_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          En,
  output logic [CW-1:0] Output,
  output logic          Overflow
);

  logic [CW-1:0] bin;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin      <= '0;
      Overflow <= 1'b0;
    end else if (En) begin
      bin <= bin + CW'(1);
      // all-ones binary is the last code; the step out of it wraps to 0
      if (&bin) Overflow <= 1'b1;
    end
  end

  assign Output = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_run_ctrl_step_down_counter.sv
// Remaining-step counter: loads a step count and counts it down to zero.
// Latency: load/dec take effect on the next Clk edge; flags are decodes of the held value.
// Backpressure: none; dec at zero is a no-op, so the count never wraps below 0.
// Ports: clk, reset (sync, high), load + load_val, dec, zero / one flags.
module step_down_counter
  import gray_run_ctrl_pkg::*;
#(
  parameter int STEPW = STEPW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [STEPW-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             one
);

  logic [STEPW-1:0] rem;

  // load wins over dec; the controller never asserts both in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
    end else if (load) begin
      rem <= load_val;
    end else if (dec && (rem != '0)) begin
      rem <= rem - STEPW'(1);
    end
  end

  assign zero = (rem == '0);
  assign one  = (rem == STEPW'(1));

endmodule

// File: rtl/gray_run_ctrl.sv
// Run sequencer for one gray counter: clear it, enable it for Steps cycles, capture the result.
// Latency: Start-to-Done = Steps+2 cycles plus one per paused RUN cycle (Steps=0: 2 cycles).
// Backpressure: Pause stalls RUN with no step consumed; Abort ends CLEAR/RUN via a 1-cycle ABORT.
// Ports: Clk, Reset (sync, high); Start/Steps/Pause/Abort command side;
//        CntValue/CntOverflow from the counter, CntEn/CntReset to it;
//        Busy, Done (1-cycle pulse), Final/OvfSeen (held captures) status side.
module gray_run_ctrl
  import gray_run_ctrl_pkg::*;
#(
  parameter int STEPW = STEPW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [STEPW-1:0] Steps,
  input  logic             Pause,
  input  logic             Abort,
  input  logic [CW-1:0]    CntValue,
  input  logic             CntOverflow,
  output logic             CntEn,
  output logic             CntReset,
  output logic             Busy,
  output logic             Done,
  output logic [CW-1:0]    Final,
  output logic             OvfSeen
);

  state_t state;
  logic   rem_zero;
  logic   rem_one;
  logic   rem_load;
  logic   rem_dec;

  // Steps is latched only when a run is accepted; a step is consumed only by
  // an unpaused, unaborted RUN cycle.
  assign rem_load = (state == S_IDLE) && Start;
  assign rem_dec  = (state == S_RUN) && !Abort && !Pause;

  step_down_counter #(.STEPW(STEPW)) u_rem (
    .clk      (Clk),
    .reset    (Reset),
    .load     (rem_load),
    .load_val (Steps),
    .dec      (rem_dec),
    .zero     (rem_zero),
    .one      (rem_one)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      Final   <= '0;
      OvfSeen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) state <= S_CLEAR;
        end
        S_CLEAR: begin
          if (Abort)         state <= S_ABORT;
          else if (rem_zero) state <= S_DONE;
          else               state <= S_RUN;
        end
        S_RUN: begin
          // Abort beats Pause beats step; the last step goes straight to DONE
          if (Abort)                 state <= S_ABORT;
          else if (!Pause && rem_one) state <= S_DONE;
        end
        S_DONE: begin
          Final   <= CntValue;
          OvfSeen <= CntOverflow;
          state   <= S_IDLE;
        end
        S_ABORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Counter is cleared alongside the controller, including on reset mid-run.
  assign CntReset = Reset || (state == S_CLEAR) || (state == S_ABORT);
  assign CntEn    = !Reset && (state == S_RUN) && !Pause;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_DONE);

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Self-checking bench: gray_run_ctrl driving a real gray_counter, checked against a cycle-count model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_gray_run_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Abort = 1'b0;
  logic [7:0] Steps = '0;
  logic [2:0] CntValue;
  logic       CntOverflow;
  logic       CntEn;
  logic       CntReset;
  logic       Busy;
  logic       Done;
  logic [2:0] Final;
  logic       OvfSeen;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference: gray code sequence and the last successfully captured result
  logic [2:0] gray_seq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic [2:0] exp_final = 3'd0;
  logic       exp_ovf   = 1'b0;

  // observations collected by do_run
  int         o_en;
  int         o_busy;
  int         o_done;
  int         o_done_cyc;
  int         o_cr;
  logic       o_end_busy;
  logic [2:0] o_end_out;

  always #5 Clk = ~Clk;

  gray_run_ctrl #(.STEPW(8), .CW(3)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Steps       (Steps),
    .Pause       (Pause),
    .Abort       (Abort),
    .CntValue    (CntValue),
    .CntOverflow (CntOverflow),
    .CntEn       (CntEn),
    .CntReset    (CntReset),
    .Busy        (Busy),
    .Done        (Done),
    .Final       (Final),
    .OvfSeen     (OvfSeen)
  );

  gray_counter #(.CW(3)) u_cnt (
    .Clk      (Clk),
    .Reset    (CntReset),
    .En       (CntEn),
    .Output   (CntValue),
    .Overflow (CntOverflow)
  );

  // Cycle 0 carries Start; cycle c is the c-th cycle after it. Pause is held
  // in cycles [pat, pat+plen); Abort is raised in cycle ab (0 = no abort).
  // Start, Steps and (after the run) Abort are randomised where they must be ignored.
  task automatic do_run(input int st, input int pat, input int plen, input int ab);
    int last;
    last = (ab > 0) ? ab + 3 : st + plen + 4;
    o_en = 0; o_busy = 0; o_done = 0; o_done_cyc = -1; o_cr = 0;
    @(posedge Clk); #1;
    Start = 1'b1; Steps = 8'(st); Pause = 1'b0; Abort = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(posedge Clk); #1;
      Start = (c <= last - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      Steps = 8'($urandom_range(0, 255));
      Pause = (plen > 0) && (c >= pat) && (c < pat + plen);
      if (ab > 0) Abort = (c == ab) || ((c >= last - 1) && ($urandom_range(0, 1) == 1));
      else        Abort = (c >= last - 2) && ($urandom_range(0, 1) == 1);
      @(negedge Clk);
      if (CntEn)    o_en++;
      if (Busy)     o_busy++;
      if (CntReset) o_cr++;
      if (Done) begin
        o_done++;
        if (o_done_cyc < 0) o_done_cyc = c;
      end
    end
    o_end_busy = Busy;
    o_end_out  = CntValue;
    Start = 1'b0; Pause = 1'b0; Abort = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Abort = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else pass_cnt++;
    chk_cnt++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else pass_cnt++;
    chk_cnt++; if (CntEn !== 1'b0) $display("FAIL reset_cnten got %b want 0", CntEn); else pass_cnt++;
    chk_cnt++; if (CntReset !== 1'b1) $display("FAIL reset_cntreset got %b want 1", CntReset); else pass_cnt++;
    chk_cnt++; if (Final !== 3'b000) $display("FAIL reset_final got %b want 000", Final); else pass_cnt++;
    chk_cnt++; if (OvfSeen !== 1'b0) $display("FAIL reset_ovfseen got %b want 0", OvfSeen); else pass_cnt++;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk_cnt++; if (CntReset !== 1'b0) $display("FAIL release_cntreset got %b want 0", CntReset); else pass_cnt++;
    chk_cnt++; if (CntValue !== 3'b000) $display("FAIL release_cntvalue got %b want 000", CntValue); else pass_cnt++;
    exp_final = 3'd0; exp_ovf = 1'b0;
  endtask

  task automatic test_basic();
    do_run(5, 0, 0, 0);
    exp_final = gray_seq[5 % 8]; exp_ovf = 1'b0;
    chk_cnt++; if (o_en !== 5) $display("FAIL basic_en_cycles got %0d want %0d", o_en, 5); else pass_cnt++;
    chk_cnt++; if (o_done_cyc !== 7) $display("FAIL basic_done_cycle got %0d want %0d", o_done_cyc, 7); else pass_cnt++;
    chk_cnt++; if (o_done !== 1) $display("FAIL basic_done_pulses got %0d want 1", o_done); else pass_cnt++;
    chk_cnt++; if (o_busy !== 7) $display("FAIL basic_busy_cycles got %0d want 7", o_busy); else pass_cnt++;
    chk_cnt++; if (Final !== exp_final) $display("FAIL basic_final got %b want %b", Final, exp_final); else pass_cnt++;
    chk_cnt++; if (OvfSeen !== exp_ovf) $display("FAIL basic_ovfseen got %b want %b", OvfSeen, exp_ovf); else pass_cnt++;
    chk_cnt++; if (o_end_out !== exp_final) $display("FAIL basic_cnt_hold got %b want %b", o_end_out, exp_final); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int sv [2] = '{9, 0};
    for (int i = 0; i < 2; i++) begin
      do_run(sv[i], 0, 0, 0);
      exp_final = gray_seq[sv[i] % 8]; exp_ovf = (sv[i] >= 8);
      chk_cnt++; if (o_en !== sv[i]) $display("FAIL wrap%0d_en_cycles got %0d want %0d", sv[i], o_en, sv[i]); else pass_cnt++;
      chk_cnt++; if (o_done_cyc !== sv[i] + 2) $display("FAIL wrap%0d_done_cycle got %0d want %0d", sv[i], o_done_cyc, sv[i] + 2); else pass_cnt++;
      chk_cnt++; if (o_done !== 1) $display("FAIL wrap%0d_done_pulses got %0d want 1", sv[i], o_done); else pass_cnt++;
      chk_cnt++; if (Final !== exp_final) $display("FAIL wrap%0d_final got %b want %b", sv[i], Final, exp_final); else pass_cnt++;
      chk_cnt++; if (OvfSeen !== exp_ovf) $display("FAIL wrap%0d_ovfseen got %b want %b", sv[i], OvfSeen, exp_ovf); else pass_cnt++;
    end
  endtask

  task automatic test_pause();
    do_run(4, 3, 3, 0);
    exp_final = gray_seq[4 % 8]; exp_ovf = 1'b0;
    chk_cnt++; if (o_en !== 4) $display("FAIL pause_en_cycles got %0d want 4", o_en); else pass_cnt++;
    chk_cnt++; if (o_done_cyc !== 9) $display("FAIL pause_done_cycle got %0d want 9", o_done_cyc); else pass_cnt++;
    chk_cnt++; if (o_busy !== 9) $display("FAIL pause_busy_cycles got %0d want 9", o_busy); else pass_cnt++;
    chk_cnt++; if (Final !== exp_final) $display("FAIL pause_final got %b want %b", Final, exp_final); else pass_cnt++;
    chk_cnt++; if (OvfSeen !== exp_ovf) $display("FAIL pause_ovfseen got %b want %b", OvfSeen, exp_ovf); else pass_cnt++;
  endtask

  // Abort in cycle 4 lands after two consumed steps (cycles 2 and 3); CntEn
  // follows ~Pause in the abort cycle too, so three enabled cycles are seen.
  task automatic test_abort();
    do_run(10, 0, 0, 4);
    chk_cnt++; if (o_done !== 0) $display("FAIL abort_done_pulses got %0d want 0", o_done); else pass_cnt++;
    chk_cnt++; if (o_cr !== 2) $display("FAIL abort_cntreset_cycles got %0d want 2", o_cr); else pass_cnt++;
    chk_cnt++; if (o_en !== 3) $display("FAIL abort_en_cycles got %0d want 3", o_en); else pass_cnt++;
    chk_cnt++; if (o_busy !== 5) $display("FAIL abort_busy_cycles got %0d want 5", o_busy); else pass_cnt++;
    chk_cnt++; if (Final !== exp_final) $display("FAIL abort_final_kept got %b want %b", Final, exp_final); else pass_cnt++;
    chk_cnt++; if (OvfSeen !== exp_ovf) $display("FAIL abort_ovf_kept got %b want %b", OvfSeen, exp_ovf); else pass_cnt++;
    chk_cnt++; if (o_end_out !== 3'b000) $display("FAIL abort_cnt_cleared got %b want 000", o_end_out); else pass_cnt++;
    chk_cnt++; if (o_end_busy !== 1'b0) $display("FAIL abort_idle got %b want 0", o_end_busy); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int st, pat, plen, ab, e_en, e_busy, e_done, e_cr;
      logic [2:0] e_out;
      st = int'($urandom_range(0, 20)); pat = 0; plen = 0; ab = 0;
      case ($urandom_range(0, 2))
        1: if (st > 0) begin plen = int'($urandom_range(1, 4)); pat = int'($urandom_range(2, st + 1)); end
        2: if (st > 0) ab = int'($urandom_range(1, st + 1));
        default: ;
      endcase
      do_run(st, pat, plen, ab);
      if (ab > 0) begin
        e_en = (ab >= 2) ? ab - 1 : 0;
        e_busy = ab + 1; e_done = 0; e_cr = 2; e_out = 3'd0;
      end else begin
        exp_final = gray_seq[st % 8]; exp_ovf = (st >= 8);
        e_en = st; e_busy = st + plen + 2; e_done = 1; e_cr = 1; e_out = exp_final;
      end
      chk_cnt++; if (o_en !== e_en) $display("FAIL rnd%0d_en_cycles got %0d want %0d", i, o_en, e_en); else pass_cnt++;
      chk_cnt++; if (o_busy !== e_busy) $display("FAIL rnd%0d_busy_cycles got %0d want %0d", i, o_busy, e_busy); else pass_cnt++;
      chk_cnt++; if (o_done !== e_done) $display("FAIL rnd%0d_done_pulses got %0d want %0d", i, o_done, e_done); else pass_cnt++;
      chk_cnt++; if (o_cr !== e_cr) $display("FAIL rnd%0d_cntreset_cycles got %0d want %0d", i, o_cr, e_cr); else pass_cnt++;
      chk_cnt++; if (Final !== exp_final) $display("FAIL rnd%0d_final got %b want %b", i, Final, exp_final); else pass_cnt++;
      chk_cnt++; if (OvfSeen !== exp_ovf) $display("FAIL rnd%0d_ovfseen got %b want %b", i, OvfSeen, exp_ovf); else pass_cnt++;
      chk_cnt++; if (o_end_out !== e_out) $display("FAIL rnd%0d_cnt_end got %b want %b", i, o_end_out, e_out); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midrun();
    // leave a non-zero capture behind so the reset has something to clear
    do_run(13, 0, 0, 0);
    exp_final = gray_seq[13 % 8]; exp_ovf = 1'b1;
    chk_cnt++; if (Final !== exp_final) $display("FAIL pre_reset_final got %b want %b", Final, exp_final); else pass_cnt++;
    @(posedge Clk); #1;
    Start = 1'b1; Steps = 8'd10;
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk);
    chk_cnt++; if (CntReset !== 1'b1) $display("FAIL midrst_cntreset got %b want 1", CntReset); else pass_cnt++;
    chk_cnt++; if (Busy !== 1'b1) $display("FAIL midrst_was_busy got %b want 1", Busy); else pass_cnt++;
    @(posedge Clk); #1;
    Reset = 1'b0;
    exp_final = 3'd0; exp_ovf = 1'b0;
    @(negedge Clk);
    chk_cnt++; if (Busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", Busy); else pass_cnt++;
    chk_cnt++; if (CntValue !== 3'b000) $display("FAIL midrst_cntvalue got %b want 000", CntValue); else pass_cnt++;
    chk_cnt++; if (Final !== exp_final) $display("FAIL midrst_final got %b want %b", Final, exp_final); else pass_cnt++;
    chk_cnt++; if (OvfSeen !== exp_ovf) $display("FAIL midrst_ovfseen got %b want %b", OvfSeen, exp_ovf); else pass_cnt++;
    chk_cnt++; if (Done !== 1'b0) $display("FAIL midrst_done got %b want 0", Done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_pause();
    test_abort();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
